// File: rtl/tlb_search_arbiter_if.sv
// tlb_search_arbiter_if
//   Bundles the three requester channels (ITLB refill, DTLB refill, CP0 TLBP),
//   the flush strobe, and the shared TLB search port (s_*).
//
//   Request handshake: a requester raises *_req with a stable *_vpn2 and keeps
//   both held until it sees its one-cycle *_done strobe or a flush. The
//   arbiter samples *_req only while idle. *_done marks the single cycle in
//   which the requester captures the TLB result.
//
//   master : requesters + TLB array side (drives req/vpn2/flush/s_found/s_index)
//   slave  : the arbiter
interface tlb_search_arbiter_if #(
    parameter int VPN2_W = 19,
    parameter int IDX_W  = 4
);
    logic              i_req;
    logic [VPN2_W-1:0] i_vpn2;
    logic              d_req;
    logic [VPN2_W-1:0] d_vpn2;
    logic              p_req;
    logic [VPN2_W-1:0] p_vpn2;
    logic              flush;
    logic              s_valid;
    logic [VPN2_W-1:0] s_vpn2;
    logic              s_found;
    logic [IDX_W-1:0]  s_index;
    logic              i_done;
    logic              d_done;
    logic              p_done;
    logic              p_found;
    logic [IDX_W-1:0]  p_index;
    logic              busy;

    modport master (
        output i_req, i_vpn2, d_req, d_vpn2, p_req, p_vpn2, flush, s_found, s_index,
        input  s_valid, s_vpn2, i_done, d_done, p_done, p_found, p_index, busy
    );

    modport slave (
        input  i_req, i_vpn2, d_req, d_vpn2, p_req, p_vpn2, flush, s_found, s_index,
        output s_valid, s_vpn2, i_done, d_done, p_done, p_found, p_index, busy
    );
endinterface

// File: rtl/tlb_search_arbiter.sv
// tlb_search_arbiter
//   Shares the single TLB search port between ITLB refill, DTLB refill and the
//   CP0 TLBP probe. One search runs at a time: IDLE grants, LOOKUP waits the
//   fixed TLB latency, RESP pulses the owner's done strobe while the TLB result
//   is on s_found/s_index.
//
//   Ports
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     bus           : tlb_search_arbiter_if.slave (requesters, flush, TLB port)
//     state_o       : current FSM state, for debug/observation
module tlb_search_arbiter #(
    parameter int VPN2_W     = 19,
    parameter int IDX_W      = 4,
    parameter int LOOKUP_LAT = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    tlb_search_arbiter_if.slave bus,
    output logic [1:0]          state_o
);
    localparam int CNT_W = 2;
    localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic [1:0] {OWN_I = 2'd0, OWN_D = 2'd1, OWN_P = 2'd2} owner_t;

    state_t            state_q;
    owner_t            owner_q;
    logic [CNT_W-1:0]  lat_cnt_q;
    logic [STV_W-1:0]  starve_q;
    logic [VPN2_W-1:0] s_vpn2_q;
    logic              p_found_q;
    logic [IDX_W-1:0]  p_index_q;
    logic              busy_q;

    logic              grant_vld_d;
    owner_t            grant_own_d;
    logic [VPN2_W-1:0] grant_vpn_d;
    logic              starved;

    // I has lost to D STARVE_MAX times in a row; it now outranks D (never P).
    assign starved = (starve_q == STV_W'(STARVE_MAX));

    always_comb begin
        grant_vld_d = bus.p_req | bus.d_req | bus.i_req;
        grant_own_d = OWN_I;
        grant_vpn_d = bus.i_vpn2;
        if (bus.p_req) begin
            grant_own_d = OWN_P;
            grant_vpn_d = bus.p_vpn2;
        end else if (bus.d_req && !(bus.i_req && starved)) begin
            grant_own_d = OWN_D;
            grant_vpn_d = bus.d_vpn2;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            lat_cnt_q <= '0;
            starve_q  <= '0;
            s_vpn2_q  <= '0;
            p_found_q <= 1'b0;
            p_index_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Flush beats a grant that would otherwise happen this cycle.
                    if (grant_vld_d && !bus.flush) begin
                        owner_q   <= grant_own_d;
                        s_vpn2_q  <= grant_vpn_d;
                        lat_cnt_q <= CNT_W'(LOOKUP_LAT - 1);
                        state_q   <= LOOKUP;
                        busy_q    <= 1'b1;
                        if (grant_own_d == OWN_I) begin
                            starve_q <= '0;
                        end else if (grant_own_d == OWN_D && bus.i_req && !starved) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end
                end
                LOOKUP: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (lat_cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    // Always back to IDLE: a satisfied requester whose req is
                    // still high is only re-sampled in the following IDLE cycle.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (owner_q == OWN_P && !bus.flush) begin
                        p_found_q <= bus.s_found;
                        p_index_q <= bus.s_index;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Done strobes decode from the state register; a flush in the RESP cycle
    // aborts the search, so it also suppresses the strobe.
    assign bus.i_done  = (state_q == RESP) && (owner_q == OWN_I) && !bus.flush;
    assign bus.d_done  = (state_q == RESP) && (owner_q == OWN_D) && !bus.flush;
    assign bus.p_done  = (state_q == RESP) && (owner_q == OWN_P) && !bus.flush;
    assign bus.s_valid = (state_q != IDLE);
    assign bus.s_vpn2  = s_vpn2_q;
    assign bus.p_found = p_found_q;
    assign bus.p_index = p_index_q;
    assign bus.busy    = busy_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_tlb_search_arbiter.sv
module tb_tlb_search_arbiter;
  localparam int VW   = 19;
  localparam int IW   = 4;
  localparam int LAT  = 1;
  localparam int SMAX = 2;
  localparam int OI   = 0;
  localparam int OD   = 1;
  localparam int OP   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: one search described by owner, latched VPN2 and the
  // cycle number of its done; grants decided from the priority rules
  bit          m_act;
  int          m_end;
  int          m_own;
  logic [VW-1:0] m_vpn;
  int          m_starve;
  logic        m_pf;
  logic [IW-1:0] m_pi;
  logic [2:0]  m_done;

  // observed done log (owner, cycle)
  int dlog_own[$];
  int dlog_cyc[$];

  tlb_search_arbiter_if #(.VPN2_W(VW), .IDX_W(IW)) bus ();

  tlb_search_arbiter #(
    .VPN2_W(VW), .IDX_W(IW), .LOOKUP_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_end = 0; m_own = OI; m_vpn = '0;
    m_starve = 0; m_pf = 1'b0; m_pi = '0; m_done = 3'b000;
  endtask

  task automatic clear_inputs();
    bus.i_req = 0; bus.d_req = 0; bus.p_req = 0; bus.flush = 0;
    bus.i_vpn2 = '0; bus.d_vpn2 = '0; bus.p_vpn2 = '0;
    bus.s_found = 0; bus.s_index = '0;
  endtask

  // one clock: check outputs at negedge, advance model with current inputs
  task automatic step();
    logic [2:0] ed;
    @(negedge clk);
    ed = 3'b000;
    if (m_act && cyc == m_end && !bus.flush) ed[m_own] = 1'b1;
    chk("s_valid", bus.s_valid, m_act);
    chk("s_vpn2",  bus.s_vpn2,  m_vpn);
    chk("i_done",  bus.i_done,  ed[OI]);
    chk("d_done",  bus.d_done,  ed[OD]);
    chk("p_done",  bus.p_done,  ed[OP]);
    chk("p_found", bus.p_found, m_pf);
    chk("p_index", bus.p_index, m_pi);
    chk("busy",    bus.busy,    m_act);
    m_done = ed;
    if (bus.i_done) begin dlog_own.push_back(OI); dlog_cyc.push_back(cyc); end
    if (bus.d_done) begin dlog_own.push_back(OD); dlog_cyc.push_back(cyc); end
    if (bus.p_done) begin dlog_own.push_back(OP); dlog_cyc.push_back(cyc); end
    if (bus.flush) begin
      m_act = 0;
    end else if (m_act) begin
      if (cyc == m_end) begin
        m_act = 0;
        if (m_own == OP) begin m_pf = bus.s_found; m_pi = bus.s_index; end
      end
    end else if (bus.p_req || bus.d_req || bus.i_req) begin
      if (bus.p_req) m_own = OP;
      else if (bus.i_req && (!bus.d_req || m_starve == SMAX)) m_own = OI;
      else m_own = OD;
      if (m_own == OI) m_starve = 0;
      if (m_own == OD && bus.i_req) m_starve = (m_starve >= SMAX) ? SMAX : m_starve + 1;
      m_vpn = (m_own == OP) ? bus.p_vpn2 : (m_own == OD) ? bus.d_vpn2 : bus.i_vpn2;
      m_act = 1;
      m_end = cyc + 1 + LAT;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver: run n cycles, requesters drop req after their (model) done
  task automatic serve(input int n, input logic [2:0] keep);
    for (int k = 0; k < n; k++) begin
      step();
      if (m_done[OI] && !keep[OI]) bus.i_req = 0;
      if (m_done[OD] && !keep[OD]) bus.d_req = 0;
      if (m_done[OP] && !keep[OP]) bus.p_req = 0;
    end
  endtask

  task automatic clear_log();
    dlog_own.delete();
    dlog_cyc.delete();
  endtask

  // asynchronous reset asserted mid-cycle, released away from the edge
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_s_valid", bus.s_valid, 0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_dones",   {bus.i_done, bus.d_done, bus.p_done}, 0);
    chk("rst_p_found", bus.p_found, 0);
    chk("rst_p_index", bus.p_index, 0);
    chk("rst_s_vpn2",  bus.s_vpn2,  0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int t0;
    model_reset();
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",   dbg_state,   0);
    chk("reset_s_valid", bus.s_valid, 0);
    chk("reset_busy",    bus.busy,    0);
    chk("reset_pfound",  bus.p_found, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // single ITLB miss: done LAT+1 cycles after the grant cycle
    clear_log();
    t0 = cyc;
    bus.i_req = 1; bus.i_vpn2 = 19'h12345; bus.s_found = 1;
    serve(4, 3'b000);
    chk("t1_ndone", dlog_own.size(), 1);
    if (dlog_own.size() == 1) begin
      chk("t1_owner",   dlog_own[0], OI);
      chk("t1_latency", dlog_cyc[0] - t0, LAT + 1);
    end

    // all three at once: order p, d, i, dones 3 cycles apart
    clear_log();
    bus.p_req = 1; bus.p_vpn2 = 19'h00111;
    bus.d_req = 1; bus.d_vpn2 = 19'h00222;
    bus.i_req = 1; bus.i_vpn2 = 19'h00333;
    serve(10, 3'b000);
    chk("t2_ndone", dlog_own.size(), 3);
    if (dlog_own.size() == 3) begin
      chk("t2_first",  dlog_own[0], OP);
      chk("t2_second", dlog_own[1], OD);
      chk("t2_third",  dlog_own[2], OI);
      chk("t2_gap_pd", dlog_cyc[1] - dlog_cyc[0], 3);
      chk("t2_gap_di", dlog_cyc[2] - dlog_cyc[1], 3);
    end

    // D held high with I pending: d, d, then I forced ahead
    clear_log();
    bus.d_req = 1; bus.d_vpn2 = 19'h0abcd;
    bus.i_req = 1; bus.i_vpn2 = 19'h05555;
    serve(9, 3'b010);
    bus.d_req = 0;
    serve(2, 3'b000);
    chk("t3_ndone", dlog_own.size(), 3);
    if (dlog_own.size() == 3) begin
      chk("t3_first",  dlog_own[0], OD);
      chk("t3_second", dlog_own[1], OD);
      chk("t3_third",  dlog_own[2], OI);
    end
    // starvation count cleared: D wins again over I
    clear_log();
    bus.d_req = 1; bus.i_req = 1;
    serve(8, 3'b000);
    chk("t3b_ndone", dlog_own.size(), 2);
    if (dlog_own.size() == 2) begin
      chk("t3b_first",  dlog_own[0], OD);
      chk("t3b_second", dlog_own[1], OI);
    end

    // TLBP hit then miss
    bus.p_req = 1; bus.p_vpn2 = 19'h00400; bus.s_found = 1; bus.s_index = 4'h9;
    serve(4, 3'b000);
    chk("t4_pfound_hit", bus.p_found, 1);
    chk("t4_pindex_hit", bus.p_index, 4'h9);
    bus.p_req = 1; bus.s_found = 0;
    serve(4, 3'b000);
    chk("t4_pfound_miss", bus.p_found, 0);
    chk("t4_pindex_held", bus.p_index, 4'h9);

    // flush during LOOKUP of a D search
    clear_log();
    bus.d_req = 1; bus.d_vpn2 = 19'h07777;
    step();
    bus.flush = 1; bus.d_req = 0;
    step();
    bus.flush = 0;
    chk("t5_sval_after_flush", bus.s_valid, 0);
    step();
    chk("t5_no_done", dlog_own.size(), 0);
    t0 = cyc;
    bus.d_req = 1;
    serve(5, 3'b000);
    chk("t5_redo_ndone", dlog_own.size(), 1);
    if (dlog_own.size() == 1) chk("t5_redo_lat", dlog_cyc[0] - t0, LAT + 1);

    // reset during LOOKUP after starvation count reached its limit
    bus.i_req = 1; bus.i_vpn2 = 19'h01010;
    bus.d_req = 1; bus.d_vpn2 = 19'h02020;
    serve(4, 3'b010);
    chk("t6_in_search", bus.s_valid, 1);
    do_reset();
    clear_log();
    bus.i_req = 1; bus.i_vpn2 = 19'h03030;
    bus.d_req = 1; bus.d_vpn2 = 19'h04040;
    serve(8, 3'b000);
    chk("t6_ndone", dlog_own.size(), 2);
    if (dlog_own.size() == 2) chk("t6_first_after_rst", dlog_own[0], OD);

    // randomized traffic against the model
    clear_inputs();
    serve(2, 3'b000);
    for (int n = 0; n < 800; n++) begin
      bus.flush   = ($urandom_range(0, 19) == 0);
      bus.s_found = 1'($urandom);
      bus.s_index = 4'($urandom);
      if (!bus.i_req && $urandom_range(0, 2) == 0) begin bus.i_req = 1; bus.i_vpn2 = 19'($urandom); end
      if (!bus.d_req && $urandom_range(0, 2) == 0) begin bus.d_req = 1; bus.d_vpn2 = 19'($urandom); end
      if (!bus.p_req && $urandom_range(0, 5) == 0) begin bus.p_req = 1; bus.p_vpn2 = 19'($urandom); end
      if ($urandom_range(0, 39) == 0) bus.d_req = 0;
      step();
      if (bus.flush) begin bus.i_req = 0; bus.d_req = 0; bus.p_req = 0; end
      if (m_done[OI] && $urandom_range(0, 3) != 0) bus.i_req = 0;
      if (m_done[OD] && $urandom_range(0, 3) != 0) bus.d_req = 0;
      if (m_done[OP]) bus.p_req = 0;
    end
    clear_inputs();
    serve(6, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
